gbuf_skew_reader: RTL

Reads a run of 128-bit words from the input global buffer and presents them to a pe_array column as a diagonally skewed word stream: lane k is delayed k cycles relative to lane 0, matching the pe chain's one-cycle-per-pe propagation. It also generates the `clear_o` and `we_o` control pulses that the pe_array consumes. It sits between the input global buffer read port and the `srca_word_i`/`clear_i`/`we_i` inputs of the first pe_array.

---
 rtl/gbuf_skew_reader_pkg.sv | 9 +
 rtl/gbuf_skew_reader_skew_line.sv | 23 ++
 rtl/gbuf_skew_reader.sv | 84 ++++++++
 3 files changed

// File: rtl/gbuf_skew_reader_pkg.sv
// gbuf_skew_reader_pkg: shared widths, feeder latencies and FSM encodings for the global buffer skew reader
package gbuf_skew_reader_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FEEDER_LANES = 8;
  localparam int WORD_WIDTH = DATA_WIDTH * FEEDER_LANES;
  localparam int FEEDER_RD_LAT = 1;
  localparam int FEEDER_DRAIN = FEEDER_RD_LAT + 1 + FEEDER_LANES - 1;
  typedef enum logic [1:0] {FEED_IDLE, FEED_READ, FEED_DRAIN, FEED_DONE} feed_state_e;
endpackage

// File: rtl/gbuf_skew_reader_skew_line.sv
// skew_line: one lane of the skew network; an output register (load-enabled) followed by DEPTH delay stages
module skew_line
  import gbuf_skew_reader_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int W = DATA_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH+1];
  // Stage 0 is the lane output register shared in timing by all lanes; later stages add the per-lane skew.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) for (int i = 0; i <= DEPTH; i++) sr[i] <= '0;
    else begin
      if (en) sr[0] <= d;
      for (int i = 1; i <= DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH];
endmodule

// File: rtl/gbuf_skew_reader.sv
// gbuf_skew_reader: reads K words from the global buffer and emits them lane-skewed to a pe_array column.
// Optional macro FEEDER_ZERO_GATE_EN zeroes each lane outside its valid window.
module gbuf_skew_reader
  import gbuf_skew_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [WORD_WIDTH-1:0] rd_data_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  clear_o,
  output logic                  we_o
);
  localparam logic [LEN_WIDTH-1:0] DRAIN_LAST = LEN_WIDTH'(FEEDER_DRAIN - 1);
  feed_state_e state, nxt;
  logic [LEN_WIDTH-1:0] cnt, len_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic v1, f1, l1;
  // State register.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= FEED_IDLE;
    else state <= nxt;
  // Next state and run status outputs; start is only looked at in IDLE so a busy run cannot be disturbed.
  always_comb begin
    nxt = state;
    busy_o = state != FEED_IDLE;
    done_o = state == FEED_DONE;
    rd_en_o = state == FEED_READ;
    case (state)
      FEED_IDLE:  if (start_i) nxt = (len_i == '0) ? FEED_DONE : FEED_READ;
      FEED_READ:  if (cnt == len_q - 1'b1) nxt = FEED_DRAIN;
      FEED_DRAIN: if (cnt == DRAIN_LAST) nxt = FEED_DONE;
      default:    nxt = FEED_IDLE;
    endcase
  end
  // Run parameters, address/phase counters, and first/last markers delayed to line up with lane 0.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt <= '0;
      len_q <= '0;
      addr <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      clear_o <= 1'b0;
      we_o <= 1'b0;
    end else begin
      if (state == FEED_IDLE && start_i) begin
        len_q <= len_i;
        addr <= base_addr_i;
      end else if (rd_en_o) addr <= addr + 1'b1;
      cnt <= (nxt != state) ? '0 : cnt + 1'b1;
      v1 <= rd_en_o;
      f1 <= rd_en_o && cnt == '0;
      l1 <= rd_en_o && cnt == len_q - 1'b1;
      clear_o <= f1;
      we_o <= l1;
    end
  assign rd_addr_o = addr;
  for (genvar k = 0; k < FEEDER_LANES; k++) begin : g_lane
`ifdef FEEDER_ZERO_GATE_EN
    logic [DATA_WIDTH:0] q;
    skew_line #(.DEPTH(k), .W(DATA_WIDTH + 1)) u_line (
      .clk_i(clk_i), .rst_ni(rst_ni), .en(1'b1),
      .d({v1, rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]}), .q(q)
    );
    assign word_o[k*DATA_WIDTH +: DATA_WIDTH] = q[DATA_WIDTH] ? q[DATA_WIDTH-1:0] : '0;
`else
    skew_line #(.DEPTH(k), .W(DATA_WIDTH)) u_line (
      .clk_i(clk_i), .rst_ni(rst_ni), .en(v1),
      .d(rd_data_i[k*DATA_WIDTH +: DATA_WIDTH]), .q(word_o[k*DATA_WIDTH +: DATA_WIDTH])
    );
`endif
  end
endmodule
